uart_rx_fifo: RTL

- Fabric-side 8N1 UART receiver. Samples a serial line driven by the AL_MCU UART TX pin and delivers received bytes to fabric logic through a small FIFO with a valid/ready handshake.
- Runs entirely in the clk25 domain, next to the MCU and LED logic in the top level.
- Its outputs (data, error and overrun flags) drive status LEDs and fabric consumers.

---
 rtl/uart_rx_fifo.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver for the MCU TX line. It oversamples at 16x in the clk25 domain
// and delivers bytes through a small first-word-fall-through FIFO with valid/ready.
module uart_rx_fifo #(
    parameter int OSR_DIV    = 14,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk25,
    input  logic             fpga_rst_n,
    input  logic             rx_in,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic [CNT_W-1:0] fifo_count,
    output logic             rx_busy
);

    localparam int DIV_W = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OSR_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]       sync_q,      sync_d;
    state_t           state_q,     state_d;
    logic [DIV_W-1:0] div_q,       div_d;
    logic [3:0]       tick_cnt_q,  tick_cnt_d;
    logic [2:0]       bit_idx_q,   bit_idx_d;
    logic [7:0]       shift_q,     shift_d;
    logic             push_q,      push_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q,   overrun_d;
    logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];

    logic rx_s;
    logic tick;
    logic pop;
    logic full;
    logic push_ok;

    assign rx_s = sync_q[1];
    assign tick = (div_q == DIV_LAST);

    // ------------------------------------------------------------------
    // Synchronizer, divider and receive FSM
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        sync_d      = {sync_q[0], rx_in};
        state_d     = state_q;
        div_d       = tick ? '0 : div_q + DIV_W'(1);
        tick_cnt_d  = tick_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        push_d      = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    // Restart the divider so ticks are phase-aligned to the start edge.
                    state_d    = S_START;
                    div_d      = '0;
                    tick_cnt_d = '0;
                end
            end

            S_START: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd7) begin
                        tick_cnt_d = '0;
                        bit_idx_d  = '0;
                        state_d    = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end

            S_DATA: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        shift_d   = {rx_s, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_d = S_STOP;
                        end
                    end
                end
            end

            S_STOP: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        if (rx_s) begin
                            push_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = S_WAIT_HIGH;
                        end
                    end
                end
            end

            S_WAIT_HIGH: begin
                // A held-low line (break) reports one error, then waits for idle.
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO control: shift_q is stable during push_q because the FSM is idle
    // ------------------------------------------------------------------
    always_comb begin
        pop       = rx_valid && rx_ready;
        full      = (count_q == CNT_FULL);
        push_ok   = push_q && (!full || pop);
        overrun_d = push_q && full && !pop;

        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = shift_q;
        end

        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk25 or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            sync_q      <= 2'b11;
            state_q     <= S_IDLE;
            div_q       <= '0;
            tick_cnt_q  <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            div_q       <= div_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // NOTE: storage is not reset; entries are only observed after being written, and rx_data is gated to 0 when empty.
    always_ff @(posedge clk25) begin
        mem_q <= mem_d;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rx_valid   = (count_q != '0);
    assign rx_data    = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign fifo_count = count_q;
    assign rx_busy    = (state_q != S_IDLE);

endmodule
